// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- instruction-fetch front end for a single-issue MIPS-style core.
//
// Owns the program counter, issues fetch requests to instruction memory and
// hands each accepted instruction, together with its address, to decode.
// The next PC is chosen from PC+4, a branch target, a J-format jump target
// or a register-sourced (JR/JALR) target.
//
// Build option:
//   BRANCH_DELAY_SLOT_EN  defined   : one architectural branch delay slot. A
//                                     redirect seen before the delay-slot fetch
//                                     completes is parked in the PEND state.
//                         undefined : no delay slot. A redirect moves the PC
//                                     immediately and squashes any fetch that
//                                     completes on the same edge.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   stall               hazard stall from decode; freezes fetch
//   branch_taken        taken conditional branch, target on branch_target
//   jump                J/JAL redirect, 26-bit index on jump_index
//   jr                  JR/JALR redirect, target on jr_target
//   imem_req/imem_addr  fetch request and address (address is always pc)
//   imem_ready/instr_in memory response and instruction word
//   pc, pc_plus4        current fetch PC and PC+4 (mod 2^32)
//   instr_out/instr_pc  last accepted instruction and its address
//   instr_valid         one-cycle pulse when instr_out/instr_pc are new
//   align_err           one-cycle pulse when an accepted jr target is misaligned

module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] instr_in,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   output logic        align_err
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      PEND  = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_out_q;
   logic [31:0] instr_pc_q;
   logic        instr_valid_q;
   logic        align_err_q;
`ifdef BRANCH_DELAY_SLOT_EN
   logic [31:0] tgt_q;
`endif

   logic        redir_req;
   logic [31:0] redir_tgt;
   logic        redir_misal;
   logic        fetch_done;

   assign imem_req   = (state_q != BOOT) && !stall;
   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign pc_plus4   = pc_q + 32'd4;
   assign fetch_done = imem_req && imem_ready;

   assign instr_out   = instr_out_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign align_err   = align_err_q;

   // Redirect decode, priority jr > jump > branch. The jump target takes its
   // top nibble from the current pc, which is the delay-slot address.
   assign redir_req   = jr || jump || branch_taken;
   assign redir_misal = jr && (jr_target[1:0] != 2'b00);

   always_comb begin
      // NOTE: default assignment first so no path leaves redir_tgt unassigned (no latch).
      redir_tgt = branch_target;
      if (jr) begin
         redir_tgt = {jr_target[31:2], 2'b00};
      end else if (jump) begin
         redir_tgt = {pc_q[31:28], jump_index, 2'b00};
      end
   end

   // Whole fetch FSM in one clocked block; every output it drives is registered.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         instr_out_q   <= 32'h0;
         instr_pc_q    <= 32'h0;
         instr_valid_q <= 1'b0;
         align_err_q   <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
         tgt_q         <= 32'h0;
`endif
      end else begin
         instr_valid_q <= 1'b0;
         align_err_q   <= 1'b0;
         case (state_q)
            BOOT: begin
               state_q <= FETCH;
            end
            default: begin
`ifdef BRANCH_DELAY_SLOT_EN
               // A redirect is only accepted from FETCH; in PEND the first target wins.
               if (state_q == FETCH && redir_req) begin
                  align_err_q <= redir_misal;
               end
               if (fetch_done) begin
                  // This completion is the delay slot when a redirect is pending
                  // or arrives on the same edge.
                  instr_out_q   <= instr_in;
                  instr_pc_q    <= pc_q;
                  instr_valid_q <= 1'b1;
                  if (state_q == PEND) begin
                     pc_q    <= tgt_q;
                     state_q <= FETCH;
                     tgt_q   <= 32'h0;
                  end else if (redir_req) begin
                     pc_q <= redir_tgt;
                  end else begin
                     pc_q <= pc_plus4;
                  end
               end else if (state_q == FETCH && redir_req) begin
                  // Also taken while stalled: redirects are sampled every edge.
                  state_q <= PEND;
                  tgt_q   <= redir_tgt;
               end
`else
               if (redir_req) begin
                  // Redirect wins outright; a same-edge completion is dropped.
                  pc_q        <= redir_tgt;
                  align_err_q <= redir_misal;
               end else if (fetch_done) begin
                  instr_out_q   <= instr_in;
                  instr_pc_q    <= pc_q;
                  instr_valid_q <= 1'b1;
                  pc_q          <= pc_plus4;
               end
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

   localparam logic [31:0] K = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump = 1'b0;
   logic [25:0] jump_index = 26'h0;
   logic        jr = 1'b0;
   logic [31:0] jr_target = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic [31:0] instr_in;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        align_err;

   int n_chk  = 0;
   int n_pass = 0;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_index   (jump_index),
      .jr           (jr),
      .jr_target    (jr_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .instr_in     (instr_in),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .instr_out    (instr_out),
      .instr_pc     (instr_pc),
      .instr_valid  (instr_valid),
      .align_err    (align_err)
   );

   always #5 clk = ~clk;

   // Memory model: each address returns a distinct word.
   assign instr_in = imem_addr ^ K;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h exp %h", pc, 32'h0); else n_pass++;
      n_chk++; if (instr_out !== 32'h0) $display("FAIL rst_instr_out: got %h exp %h", instr_out, 32'h0); else n_pass++;
      n_chk++; if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc: got %h exp %h", instr_pc, 32'h0); else n_pass++;
      n_chk++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", instr_valid); else n_pass++;
      n_chk++; if (align_err !== 1'b0) $display("FAIL rst_align: got %b exp 0", align_err); else n_pass++;
      n_chk++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", imem_req); else n_pass++;
      reset = 1'b0;
      #2;
      n_chk++; if (imem_req !== 1'b0) $display("FAIL boot_req: got %b exp 0", imem_req); else n_pass++;
      step();
      n_chk++; if (imem_req !== 1'b1) $display("FAIL fetch_req: got %b exp 1", imem_req); else n_pass++;
      n_chk++; if (instr_valid !== 1'b0) $display("FAIL boot_valid: got %b exp 0", instr_valid); else n_pass++;
      n_chk++; if (pc !== 32'h0) $display("FAIL boot_pc: got %h exp %h", pc, 32'h0); else n_pass++;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++; if (instr_pc !== 32'(i * 4)) $display("FAIL seq_instr_pc: got %h exp %h", instr_pc, 32'(i * 4)); else n_pass++;
         n_chk++; if (instr_valid !== 1'b1) $display("FAIL seq_valid: got %b exp 1", instr_valid); else n_pass++;
         n_chk++; if (instr_out !== (32'(i * 4) ^ K)) $display("FAIL seq_instr_out: got %h exp %h", instr_out, 32'(i * 4) ^ K); else n_pass++;
      end
      n_chk++; if (pc !== 32'h8) $display("FAIL seq_pc: got %h exp %h", pc, 32'h8); else n_pass++;
   endtask

   task automatic test_wait_state();
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++; if (imem_addr !== 32'h8) $display("FAIL wait_addr: got %h exp %h", imem_addr, 32'h8); else n_pass++;
         n_chk++; if (instr_valid !== 1'b0) $display("FAIL wait_valid: got %b exp 0", instr_valid); else n_pass++;
      end
      imem_ready = 1'b1;
      step();
      n_chk++; if (instr_pc !== 32'h8) $display("FAIL wait_instr_pc: got %h exp %h", instr_pc, 32'h8); else n_pass++;
      n_chk++; if (instr_valid !== 1'b1) $display("FAIL wait_valid_end: got %b exp 1", instr_valid); else n_pass++;
      n_chk++; if (pc !== 32'hC) $display("FAIL wait_pc: got %h exp %h", pc, 32'hC); else n_pass++;
   endtask

   // jr to the top word on a completion edge, then wrap past 2^32.
   task automatic test_wrap(input logic exp_valid);
      jr = 1'b1; jr_target = 32'hFFFF_FFFC;
      step();
      jr = 1'b0;
      n_chk++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_top: got %h exp %h", pc, 32'hFFFF_FFFC); else n_pass++;
      n_chk++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_plus4: got %h exp %h", pc_plus4, 32'h0); else n_pass++;
      n_chk++; if (instr_valid !== exp_valid) $display("FAIL wrap_redir_valid: got %b exp %b", instr_valid, exp_valid); else n_pass++;
      step();
      n_chk++; if (instr_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_instr_pc: got %h exp %h", instr_pc, 32'hFFFF_FFFC); else n_pass++;
      n_chk++; if (pc !== 32'h0) $display("FAIL wrap_pc: got %h exp %h", pc, 32'h0); else n_pass++;
   endtask

`ifdef BRANCH_DELAY_SLOT_EN
   task automatic test_branch_delay();
      step();
      n_chk++; if (pc !== 32'h10) $display("FAIL bd_pre_pc: got %h exp %h", pc, 32'h10); else n_pass++;
      imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
      step();
      branch_taken = 1'b0;
      n_chk++; if (pc !== 32'h10) $display("FAIL bd_pend_pc: got %h exp %h", pc, 32'h10); else n_pass++;
      n_chk++; if (instr_valid !== 1'b0) $display("FAIL bd_pend_valid: got %b exp 0", instr_valid); else n_pass++;
      imem_ready = 1'b1;
      step();
      n_chk++; if (instr_pc !== 32'h10) $display("FAIL bd_slot_pc: got %h exp %h", instr_pc, 32'h10); else n_pass++;
      n_chk++; if (pc !== 32'h40) $display("FAIL bd_target: got %h exp %h", pc, 32'h40); else n_pass++;
      step();
      n_chk++; if (instr_pc !== 32'h40) $display("FAIL bd_tgt_fetch: got %h exp %h", instr_pc, 32'h40); else n_pass++;
      n_chk++; if (pc !== 32'h44) $display("FAIL bd_after_pc: got %h exp %h", pc, 32'h44); else n_pass++;
   endtask

   task automatic test_stall_pend();
      imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
      step();
      branch_taken = 1'b0;
      imem_ready = 1'b1; stall = 1'b1; jump = 1'b1; jump_index = 26'h123;
      #1;
      n_chk++; if (imem_req !== 1'b0) $display("FAIL sp_req: got %b exp 0", imem_req); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++; if (instr_valid !== 1'b0) $display("FAIL sp_valid: got %b exp 0", instr_valid); else n_pass++;
         n_chk++; if (pc !== 32'h44) $display("FAIL sp_pc: got %h exp %h", pc, 32'h44); else n_pass++;
      end
      stall = 1'b0; jump = 1'b0;
      step();
      n_chk++; if (instr_pc !== 32'h44) $display("FAIL sp_slot: got %h exp %h", instr_pc, 32'h44); else n_pass++;
      n_chk++; if (pc !== 32'h200) $display("FAIL sp_target: got %h exp %h", pc, 32'h200); else n_pass++;
      step();
      n_chk++; if (instr_pc !== 32'h200) $display("FAIL sp_tgt_fetch: got %h exp %h", instr_pc, 32'h200); else n_pass++;
   endtask

   task automatic test_jr_priority();
      jr = 1'b1; jr_target = 32'h2000_0010;
      step();
      jr = 1'b0;
      n_chk++; if (instr_pc !== 32'h204) $display("FAIL jp_slot0: got %h exp %h", instr_pc, 32'h204); else n_pass++;
      n_chk++; if (pc !== 32'h2000_0010) $display("FAIL jp_pc0: got %h exp %h", pc, 32'h2000_0010); else n_pass++;
      imem_ready = 1'b0; jr = 1'b1; jump = 1'b1; jr_target = 32'h103; jump_index = 26'h3;
      step();
      jr = 1'b0; jump = 1'b0;
      n_chk++; if (align_err !== 1'b1) $display("FAIL jp_align: got %b exp 1", align_err); else n_pass++;
      n_chk++; if (pc !== 32'h2000_0010) $display("FAIL jp_pend_pc: got %h exp %h", pc, 32'h2000_0010); else n_pass++;
      imem_ready = 1'b1;
      step();
      n_chk++; if (align_err !== 1'b0) $display("FAIL jp_align_clr: got %b exp 0", align_err); else n_pass++;
      n_chk++; if (instr_pc !== 32'h2000_0010) $display("FAIL jp_slot: got %h exp %h", instr_pc, 32'h2000_0010); else n_pass++;
      n_chk++; if (pc !== 32'h100) $display("FAIL jp_target: got %h exp %h", pc, 32'h100); else n_pass++;
   endtask

   task automatic test_reset_pend();
      imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
      step();
      branch_taken = 1'b0;
      reset = 1'b1;
      #2;
      n_chk++; if (pc !== 32'h0) $display("FAIL rp_pc: got %h exp %h", pc, 32'h0); else n_pass++;
      n_chk++; if (imem_req !== 1'b0) $display("FAIL rp_req: got %b exp 0", imem_req); else n_pass++;
      reset = 1'b0; imem_ready = 1'b1;
      step();
      step();
      n_chk++; if (instr_pc !== 32'h0) $display("FAIL rp_instr_pc: got %h exp %h", instr_pc, 32'h0); else n_pass++;
      n_chk++; if (pc !== 32'h4) $display("FAIL rp_next_pc: got %h exp %h", pc, 32'h4); else n_pass++;
   endtask
`else
   task automatic test_jump_squash();
      jump = 1'b1; jump_index = 26'h3FF_FFFF;
      step();
      jump = 1'b0;
      n_chk++; if (instr_valid !== 1'b0) $display("FAIL js_valid: got %b exp 0", instr_valid); else n_pass++;
      n_chk++; if (instr_pc !== 32'h8) $display("FAIL js_instr_pc: got %h exp %h", instr_pc, 32'h8); else n_pass++;
      n_chk++; if (pc !== 32'h0FFF_FFFC) $display("FAIL js_pc: got %h exp %h", pc, 32'h0FFF_FFFC); else n_pass++;
      step();
      n_chk++; if (instr_pc !== 32'h0FFF_FFFC) $display("FAIL js_fetch: got %h exp %h", instr_pc, 32'h0FFF_FFFC); else n_pass++;
      n_chk++; if (pc !== 32'h1000_0000) $display("FAIL js_next: got %h exp %h", pc, 32'h1000_0000); else n_pass++;
   endtask

   task automatic test_branch_squash();
      jr = 1'b1; jr_target = 32'h20;
      step();
      jr = 1'b0;
      n_chk++; if (pc !== 32'h20) $display("FAIL bs_pre_pc: got %h exp %h", pc, 32'h20); else n_pass++;
      branch_taken = 1'b1; branch_target = 32'h80;
      step();
      branch_taken = 1'b0;
      n_chk++; if (instr_valid !== 1'b0) $display("FAIL bs_valid: got %b exp 0", instr_valid); else n_pass++;
      n_chk++; if (instr_pc !== 32'h0FFF_FFFC) $display("FAIL bs_hold_pc: got %h exp %h", instr_pc, 32'h0FFF_FFFC); else n_pass++;
      n_chk++; if (pc !== 32'h80) $display("FAIL bs_pc: got %h exp %h", pc, 32'h80); else n_pass++;
      step();
      n_chk++; if (instr_pc !== 32'h80) $display("FAIL bs_fetch: got %h exp %h", instr_pc, 32'h80); else n_pass++;
      n_chk++; if (instr_out !== (32'h80 ^ K)) $display("FAIL bs_instr: got %h exp %h", instr_out, 32'h80 ^ K); else n_pass++;
   endtask

   task automatic test_jr_priority();
      jr = 1'b1; jump = 1'b1; branch_taken = 1'b1;
      jr_target = 32'h103; jump_index = 26'h3; branch_target = 32'h500;
      step();
      jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      n_chk++; if (align_err !== 1'b1) $display("FAIL jp_align: got %b exp 1", align_err); else n_pass++;
      n_chk++; if (pc !== 32'h100) $display("FAIL jp_pc: got %h exp %h", pc, 32'h100); else n_pass++;
      step();
      n_chk++; if (align_err !== 1'b0) $display("FAIL jp_align_clr: got %b exp 0", align_err); else n_pass++;
      n_chk++; if (instr_pc !== 32'h100) $display("FAIL jp_fetch: got %h exp %h", instr_pc, 32'h100); else n_pass++;
   endtask

   task automatic test_stall();
      stall = 1'b1;
      #1;
      n_chk++; if (imem_req !== 1'b0) $display("FAIL st_req: got %b exp 0", imem_req); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++; if (instr_valid !== 1'b0) $display("FAIL st_valid: got %b exp 0", instr_valid); else n_pass++;
         n_chk++; if (pc !== 32'h104) $display("FAIL st_pc: got %h exp %h", pc, 32'h104); else n_pass++;
      end
      stall = 1'b0;
      step();
      n_chk++; if (instr_pc !== 32'h104) $display("FAIL st_release: got %h exp %h", instr_pc, 32'h104); else n_pass++;
      n_chk++; if (pc !== 32'h108) $display("FAIL st_next: got %h exp %h", pc, 32'h108); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_sequential();
      test_wait_state();
`ifdef BRANCH_DELAY_SLOT_EN
      test_branch_delay();
      test_stall_pend();
      test_jr_priority();
      test_wrap(1'b1);
      test_reset_pend();
`else
      test_jump_squash();
      test_branch_squash();
      test_jr_priority();
      test_stall();
      test_wrap(1'b0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
